// File: rtl/lfsr_input_conditioner_pkg.sv
// Shared constants for the button/switch conditioner and the LFSR stage it feeds.
package lfsr_input_conditioner_pkg;

   localparam int unsigned LFSR_WIDTH          = 5;
   localparam int unsigned CLOCK_FREQ_DEFAULT  = 1000;
   localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;

   // Number of clock cycles a synchronised level must persist to be accepted.
   function automatic int unsigned debounce_ticks(input int unsigned freq_hz,
                                                  input int unsigned window_ms);
      return (freq_hz * window_ms) / 1000;
   endfunction

endpackage

// File: rtl/debouncer.sv
// Single-input debouncer: accepts a new level after TICKS consecutive samples
// that differ from the current one, and strobes for one cycle on each accepted rise.
module debouncer #(
   parameter int unsigned TICKS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic level,
   output logic rise,
   output logic rise_c
);

   localparam int unsigned   CW   = $clog2(TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;

   // Any sample equal to the accepted level restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise_d   = 1'b0;
      if (in != stable_q) begin
         if (cnt_q == LAST) begin
            stable_d = in;
            rise_d   = in;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
      end
   end

   assign level  = stable_q;
   assign rise   = rise_q;
   // Lookahead of the strobe, so a consumer can capture data on the same edge.
   assign rise_c = rise_d;

endmodule

// File: rtl/lfsr_input_conditioner.sv
// Synchronises and debounces the LFSR load buttons and captures the switch word
// alongside each clean one-shot load strobe.
module lfsr_input_conditioner
   import lfsr_input_conditioner_pkg::*;
#(
   parameter int unsigned DATA_BITS   = LFSR_WIDTH,
   parameter int unsigned CLOCK_FREQ  = CLOCK_FREQ_DEFAULT,
   parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_lfsr,
   input  logic                 btn_taps,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 load_lfsr,
   output logic                 load_taps,
   output logic [DATA_BITS-1:0] data_out,
   output logic [1:0]           btn_state
);

   localparam int unsigned DEBOUNCE_TICKS = debounce_ticks(CLOCK_FREQ, DEBOUNCE_MS);

   logic [1:0]           btn_meta_q, btn_sync_q;   // {taps, lfsr}
   logic [DATA_BITS-1:0] data_meta_q, data_sync_q;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 lfsr_level, lfsr_rise, lfsr_rise_c;
   logic                 taps_level, taps_rise, taps_rise_c;

   // Two-flop synchronisers for every asynchronous pin.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta_q  <= '0;
         btn_sync_q  <= '0;
         data_meta_q <= '0;
         data_sync_q <= '0;
      end else begin
         btn_meta_q  <= {btn_taps, btn_lfsr};
         btn_sync_q  <= btn_meta_q;
         data_meta_q <= data_in;
         data_sync_q <= data_meta_q;
      end
   end

   debouncer #(.TICKS(DEBOUNCE_TICKS)) u_deb_lfsr (
      .clk    (clk),
      .reset  (reset),
      .in     (btn_sync_q[0]),
      .level  (lfsr_level),
      .rise   (lfsr_rise),
      .rise_c (lfsr_rise_c)
   );

   debouncer #(.TICKS(DEBOUNCE_TICKS)) u_deb_taps (
      .clk    (clk),
      .reset  (reset),
      .in     (btn_sync_q[1]),
      .level  (taps_level),
      .rise   (taps_rise),
      .rise_c (taps_rise_c)
   );

   // Simultaneous strobes share one captured word.
   always_comb begin
      data_out_d = data_out_q;
      if (lfsr_rise_c || taps_rise_c) begin
         data_out_d = data_sync_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   assign load_lfsr = lfsr_rise;
   assign load_taps = taps_rise;
   assign data_out  = data_out_q;
   assign btn_state = {taps_level, lfsr_level};

endmodule

// File: tb/tb_lfsr_input_conditioner.sv
// Scoreboard bench: a window-based debounce model predicts strobes and levels;
// a negedge monitor compares every cycle against the predictions.
module tb_lfsr_input_conditioner;

   localparam int unsigned T = 4;

   typedef struct {
      int       cyc;
      bit       l;
      bit       t;
      bit [4:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_lfsr = 1'b0;
   logic       btn_taps = 1'b0;
   logic [4:0] data_in = '0;
   logic       load_lfsr, load_taps;
   logic [4:0] data_out;
   logic [1:0] btn_state;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model state: raw samples from one and two edges ago, last-T seen samples.
   exp_t     exp_q[$];
   bit [1:0] r_d1, r_d2;
   bit [4:0] dat_d1, dat_d2;
   bit       seen_l[$];
   bit       seen_t[$];
   bit       st_l, st_t;
   bit [4:0] m_data;

   // Monitor observations used by directed checks.
   int       n_l = 0, n_t = 0, last_l = -1, last_t = -1;
   bit [1:0] state_or = '0;

   lfsr_input_conditioner #(
      .DATA_BITS   (5),
      .CLOCK_FREQ  (1000),
      .DEBOUNCE_MS (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_lfsr  (btn_lfsr),
      .btn_taps  (btn_taps),
      .data_in   (data_in),
      .load_lfsr (load_lfsr),
      .load_taps (load_taps),
      .data_out  (data_out),
      .btn_state (btn_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // A level is accepted once the last T synchronised samples all differ from it.
   function automatic bit all_differ(input bit q[$], input bit st);
      if (q.size() != T) return 1'b0;
      foreach (q[i]) if (q[i] == st) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input bit rst, input bit bl, input bit bt, input bit [4:0] d);
      bit   rl, rt;
      exp_t e;
      if (rst) begin
         r_d1 = '0; r_d2 = '0; dat_d1 = '0; dat_d2 = '0;
         seen_l.delete(); seen_t.delete();
         st_l = 1'b0; st_t = 1'b0; m_data = '0;
         return;
      end
      seen_l.push_back(r_d2[0]);
      if (seen_l.size() > T) void'(seen_l.pop_front());
      seen_t.push_back(r_d2[1]);
      if (seen_t.size() > T) void'(seen_t.pop_front());
      rl = 1'b0;
      rt = 1'b0;
      if (all_differ(seen_l, st_l)) begin rl = !st_l; st_l = !st_l; end
      if (all_differ(seen_t, st_t)) begin rt = !st_t; st_t = !st_t; end
      if (rl || rt) begin
         m_data = dat_d2;
         e.cyc = cyc; e.l = rl; e.t = rt; e.data = dat_d2;
         exp_q.push_back(e);
      end
      r_d2   = r_d1;
      r_d1   = {bt, bl};
      dat_d2 = dat_d1;
      dat_d1 = d;
   endtask

   task automatic step(input bit rst, input bit bl, input bit bt, input bit [4:0] d);
      reset    = rst;
      btn_lfsr = bl;
      btn_taps = bt;
      data_in  = d;
      @(posedge clk);
      cyc++;
      model_edge(rst, bl, bt, d);
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit rst, input bit bl, input bit bt, input bit [4:0] d);
      for (int i = 0; i < n; i++) step(rst, bl, bt, d);
   endtask

   // Monitor: pops the scoreboard whenever a strobe is due and checks levels/data.
   always @(negedge clk) begin
      bit [1:0] want;
      exp_t     e;
      if (cyc > 0) begin
         want = '0;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e    = exp_q.pop_front();
            want = {e.t, e.l};
            check("strobe_data", int'(data_out), int'(e.data));
         end
         check("strobes", int'({load_taps, load_lfsr}), int'(want));
         check("data_out", int'(data_out), int'(m_data));
         check("btn_state", int'(btn_state), int'({st_t, st_l}));
         if (load_lfsr) begin n_l++; last_l = cyc; end
         if (load_taps) begin n_t++; last_t = cyc; end
         state_or = state_or | btn_state;
      end
   end

   initial begin
      int       bl_n, bt_n, e0;
      int       hl, ht;
      bit       bl, bt;

      // Reset state
      run(3, 1'b1, 1'b0, 1'b0, 5'h00);
      check("reset_data", int'(data_out), 0);
      check("reset_state", int'(btn_state), 0);
      check("reset_strobe", int'({load_taps, load_lfsr}), 0);
      run(6, 1'b0, 1'b0, 1'b0, 5'h13);

      // Clean press
      bl_n = n_l; bt_n = n_t; e0 = cyc + 1;
      run(8, 1'b0, 1'b1, 1'b0, 5'h13);
      check("clean_count", n_l - bl_n, 1);
      check("clean_cycle", last_l, e0 + 5);
      check("clean_taps", n_t - bt_n, 0);
      check("clean_data", int'(data_out), 'h13);
      run(10, 1'b0, 1'b0, 1'b0, 5'h13);

      // Bounce on taps
      bt_n = n_t;
      run(3, 1'b0, 1'b0, 1'b1, 5'h13);
      run(1, 1'b0, 1'b0, 1'b0, 5'h13);
      e0 = cyc + 1;
      run(10, 1'b0, 1'b0, 1'b1, 5'h13);
      check("bounce_count", n_t - bt_n, 1);
      check("bounce_cycle", last_t, e0 + 5);
      run(10, 1'b0, 1'b0, 1'b0, 5'h13);

      // Glitch reject
      bl_n = n_l; state_or = '0;
      run(3, 1'b0, 1'b1, 1'b0, 5'h13);
      run(10, 1'b0, 1'b0, 1'b0, 5'h13);
      check("glitch_count", n_l - bl_n, 0);
      check("glitch_state", int'(state_or), 0);

      // Simultaneous press
      run(4, 1'b0, 1'b0, 1'b0, 5'h0A);
      bl_n = n_l; bt_n = n_t; e0 = cyc + 1;
      run(10, 1'b0, 1'b1, 1'b1, 5'h0A);
      check("simul_lfsr", n_l - bl_n, 1);
      check("simul_taps", n_t - bt_n, 1);
      check("simul_cyc_l", last_l, e0 + 5);
      check("simul_cyc_t", last_t, e0 + 5);
      check("simul_data", int'(data_out), 'h0A);

      // Hold while data changes, then re-press
      bl_n = n_l; bt_n = n_t;
      run(12, 1'b0, 1'b1, 1'b0, 5'h1F);
      check("hold_count", (n_l - bl_n) + (n_t - bt_n), 0);
      check("hold_data", int'(data_out), 'h0A);
      run(10, 1'b0, 1'b0, 1'b0, 5'h1F);
      bl_n = n_l; e0 = cyc + 1;
      run(8, 1'b0, 1'b1, 1'b0, 5'h1F);
      check("repress_count", n_l - bl_n, 1);
      check("repress_cycle", last_l, e0 + 5);
      check("repress_data", int'(data_out), 'h1F);
      run(10, 1'b0, 1'b0, 1'b0, 5'h05);

      // Reset mid-count, button held through deassertion
      bl_n = n_l;
      run(4, 1'b0, 1'b1, 1'b0, 5'h05);
      run(2, 1'b1, 1'b1, 1'b0, 5'h05);
      check("rst_count", n_l - bl_n, 0);
      check("rst_data", int'(data_out), 0);
      check("rst_state", int'(btn_state), 0);
      e0 = cyc + 1;
      run(8, 1'b0, 1'b1, 1'b0, 5'h05);
      check("rst_hold_count", n_l - bl_n, 1);
      check("rst_hold_cycle", last_l, e0 + 5);
      check("rst_hold_data", int'(data_out), 'h05);
      run(10, 1'b0, 1'b0, 1'b0, 5'h05);

      // Randomised button activity, data and occasional resets
      hl = 0; ht = 0; bl = 1'b0; bt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (hl == 0) begin bl = 1'($urandom_range(0, 1)); hl = $urandom_range(1, 12); end
         if (ht == 0) begin bt = 1'($urandom_range(0, 1)); ht = $urandom_range(1, 12); end
         hl--;
         ht--;
         step($urandom_range(0, 299) == 0, bl, bt, 5'($urandom));
      end

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
